i2s_timing: RTL and testbench
=============================

# i2s_timing

Bit-clock and frame timing generator for the I2S receive path. Divides the 12.288 MHz master clock into the serial bit clock (SCLK) and word-select clock (LRCLK) driven to the codec. It also produces the per-bit sample strobe, bit index, channel flag and frame-complete pulse consumed directly by `i2s_rx`. It sits between the clock domain root and `i2s_rx`, in the same clock domain.

## Interface
Parameters:
- `DATA_BIT`, default `` `DATA_BIT `` (24): audio word width; must satisfy `DATA_BIT <= SLOT_BIT-1`.
- `SLOT_BIT`, default 32: SCLK periods per channel slot.
- `SCLK_DIV`, default 4: master-clock cycles per SCLK period; even, ≥2. Defaults give 48 kHz frames (256 cycles).

Ports:
- `i_clk_12_288`  in  1  master clock; all logic on rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_enable`  in  1  run when high; when low, idle and hold the reset state.
- `o_sclk`  out  1  bit-clock pin level.
- `o_lrclk`  out  1  word-select pin level; 0 = left, 1 = right.
- `o_sclk_rise`  out  1  one-cycle strobe in the first cycle `o_sclk` is high (sample point); feeds `i2s_rx.i_sclk`.
- `o_sclk_fall`  out  1  one-cycle strobe in the first cycle `o_sclk` is low after a high phase.
- `o_count`  out  `$clog2(DATA_BIT)`  bit index of the current SCLK period (MSB = `DATA_BIT-1`).
- `o_count_valid`  out  1  current SCLK period carries a data bit.
- `o_count_lrclk`  out  1  channel of the current data bit.
- `o_finish`  out  1  one-cycle pulse when both channel words are complete.

## Operation
- Internal `div_cnt` counts 0..SCLK_DIV-1 and wraps. Internal `bit_cnt` counts 0..2*SLOT_BIT-1, increments when `div_cnt` wraps to 0, then wraps to 0 after 2*SLOT_BIT-1.
- `o_sclk` = 1 iff `div_cnt >= SCLK_DIV/2`.
- `o_sclk_rise` = (`div_cnt == SCLK_DIV/2`). `o_sclk_fall` = (`div_cnt == 0`) and not the first cycle after enable.
- `o_lrclk` = (`bit_cnt >= SLOT_BIT`).
- Slot position `p = bit_cnt mod SLOT_BIT`. I2S one-bit delay applies: `o_count_valid` = (1 ≤ p ≤ DATA_BIT), `o_count` = DATA_BIT − p when valid, else 0. `o_count_lrclk` = `o_lrclk`. These three are held constant for a whole SCLK period.
- `o_finish` = (`bit_cnt == SLOT_BIT+DATA_BIT+1` and `div_cnt == 0`). This is SCLK_DIV/2 cycles after the right LSB is sampled, so `i2s_rx`'s shift register is already updated.
- Counters update on the same edge; all outputs are decoded from registered counter state, with no combinational path from inputs.
- Reset, or `i_enable` low: `div_cnt`, `bit_cnt` = 0; every output = 0, including `o_sclk`, `o_lrclk` and all strobes.
- Deasserting `i_enable` mid-frame aborts the frame immediately, with no `o_finish`. Re-enable always restarts at `bit_cnt = 0`, left channel.
- Reset has priority over `i_enable`.

## Timing
- Define cycle 0 as the first cycle with `i_enable` high and reset low. In cycle n, `div_cnt = n mod SCLK_DIV` and `bit_cnt = floor(n/SCLK_DIV) mod 2*SLOT_BIT`.
- Defaults (DIV=4, SLOT=32, DATA=24):
  - `o_sclk` is high in cycles 2,3 of every 4.
  - Rise strobes occur at 4k+2.
  - `o_lrclk` rises at cycle 128 and falls at 256.
  - Left MSB (`count=23`, valid) rise is at cycle 6; left LSB (`count=0`) rise is at 98.
  - Right MSB rise is at 134; right LSB rise is at 226.
  - `o_finish` is at 228, then every 256 cycles (484, 740, ...).
- Frame period is exactly 2·SLOT_BIT·SCLK_DIV cycles with no jitter. Strobes are never asserted in two consecutive cycles.

## Test plan
- Reset/idle: `i_reset=1` for 5 cycles, then `i_enable=0` for 20 cycles → every output stays 0 throughout.
- Clock generation: enable 1024 cycles → `o_sclk` period 4 with 2/2 duty; `o_lrclk` period 256 with transitions at 128 mod 256; 256 rise strobes and 4 `o_finish` pulses at 228/484/740/996.
- Bit indexing: over one frame, `o_count_valid` is high for exactly 48 SCLK periods. `o_count` runs 23→0 during `bit_cnt` 1–24 (left) and 33–56 (right), and is 0 and invalid elsewhere.
- Loopback with `i2s_rx`: model a codec driving 0xA5C3F1 left and 0x123456 right on SCLK falling edges → `o_audio_l`/`o_audio_r` equal those values the cycle after `o_finish` (229).
- Mid-frame abort: drop `i_enable` at cycle 150, re-enable at 200 → outputs are 0 at cycle 151. The new frame starts with cycle 0 at 201; no `o_finish` occurs until cycle 429.
- Reset priority: assert `i_reset` with `i_enable=1` at cycle 100 for one cycle → all outputs 0 next cycle; restart with cycle 0 = 102.

Source files
------------

// File: rtl/i2s_timing.sv
// I2S bit-clock / word-select generator for the receive path: divides the master
// clock into SCLK and LRCLK and decodes per-bit strobes, bit index and frame pulse.
`ifndef DATA_BIT
`define DATA_BIT 24
`endif

module i2s_timing #(
    parameter int DATA_BIT = `DATA_BIT,
    parameter int SLOT_BIT = 32,
    parameter int SCLK_DIV = 4
) (
    input  logic                        i_clk_12_288,
    input  logic                        i_reset,
    input  logic                        i_enable,
    output logic                        o_sclk,
    output logic                        o_lrclk,
    output logic                        o_sclk_rise,
    output logic                        o_sclk_fall,
    output logic [$clog2(DATA_BIT)-1:0] o_count,
    output logic                        o_count_valid,
    output logic                        o_count_lrclk,
    output logic                        o_finish
);

    localparam int DIV_W = $clog2(SCLK_DIV);
    localparam int BIT_W = $clog2(2 * SLOT_BIT);
    localparam int CNT_W = $clog2(DATA_BIT);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BIT - 1);
    localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_BIT);
    localparam logic [BIT_W-1:0] DATA_LEN = BIT_W'(DATA_BIT);
    localparam logic [BIT_W-1:0] FIN_BIT  = BIT_W'(SLOT_BIT + DATA_BIT + 1);

    logic [DIV_W-1:0] div_cnt_r;
    logic [BIT_W-1:0] bit_cnt_r;
    logic             run_r;

    logic [DIV_W-1:0] div_cnt_s;
    logic [BIT_W-1:0] bit_cnt_s;
    logic             run_s;
    logic             first_s;
    logic [BIT_W-1:0] pos_s;
    logic [BIT_W-1:0] idx_s;
    logic             sclk_s;
    logic             lrclk_s;
    logic             rise_s;
    logic             fall_s;
    logic             valid_s;
    logic [CNT_W-1:0] count_s;
    logic             finish_s;

    // Counter next state; the first enabled cycle only arms run_r so every frame starts from zero.
    always_comb begin
        div_cnt_s = div_cnt_r;
        bit_cnt_s = bit_cnt_r;
        run_s     = 1'b0;
        first_s   = 1'b0;
        if (!i_enable) begin
            div_cnt_s = {DIV_W{1'b0}};
            bit_cnt_s = {BIT_W{1'b0}};
        end else begin
            run_s   = 1'b1;
            first_s = !run_r;
            if (!run_r) begin
                div_cnt_s = {DIV_W{1'b0}};
                bit_cnt_s = {BIT_W{1'b0}};
            end else if (div_cnt_r == DIV_LAST) begin
                div_cnt_s = {DIV_W{1'b0}};
                if (bit_cnt_r == BIT_LAST) begin
                    bit_cnt_s = {BIT_W{1'b0}};
                end else begin
                    bit_cnt_s = bit_cnt_r + BIT_W'(1);
                end
            end else begin
                div_cnt_s = div_cnt_r + DIV_W'(1);
            end
        end
    end

    // Output decode from next counter state, so registered outputs line up with the counters.
    always_comb begin
        pos_s    = (bit_cnt_s >= SLOT_LEN) ? (bit_cnt_s - SLOT_LEN) : bit_cnt_s;
        idx_s    = DATA_LEN - pos_s;
        sclk_s   = run_s && (div_cnt_s >= DIV_HALF);
        rise_s   = run_s && (div_cnt_s == DIV_HALF);
        fall_s   = run_s && !first_s && (div_cnt_s == {DIV_W{1'b0}});
        lrclk_s  = run_s && (bit_cnt_s >= SLOT_LEN);
        // One-bit I2S delay: slot position 0 carries no data, MSB sits at position 1.
        valid_s  = run_s && (pos_s != {BIT_W{1'b0}}) && (pos_s <= DATA_LEN);
        finish_s = run_s && (bit_cnt_s == FIN_BIT) && (div_cnt_s == {DIV_W{1'b0}});
        if (valid_s) begin
            count_s = idx_s[CNT_W-1:0];
        end else begin
            count_s = {CNT_W{1'b0}};
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk_12_288) begin
        if (i_reset) begin
            div_cnt_r     <= {DIV_W{1'b0}};
            bit_cnt_r     <= {BIT_W{1'b0}};
            run_r         <= 1'b0;
            o_sclk        <= 1'b0;
            o_lrclk       <= 1'b0;
            o_sclk_rise   <= 1'b0;
            o_sclk_fall   <= 1'b0;
            o_count       <= {CNT_W{1'b0}};
            o_count_valid <= 1'b0;
            o_count_lrclk <= 1'b0;
            o_finish      <= 1'b0;
        end else begin
            div_cnt_r     <= div_cnt_s;
            bit_cnt_r     <= bit_cnt_s;
            run_r         <= run_s;
            o_sclk        <= sclk_s;
            o_lrclk       <= lrclk_s;
            o_sclk_rise   <= rise_s;
            o_sclk_fall   <= fall_s;
            o_count       <= count_s;
            o_count_valid <= valid_s;
            o_count_lrclk <= lrclk_s;
            o_finish      <= finish_s;
        end
    end

endmodule

// File: tb/tb_i2s_timing.sv
// Directed self-checking bench for i2s_timing with default parameters
// (SCLK_DIV=4, SLOT_BIT=32, DATA_BIT=24).
module tb_i2s_timing;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       sclk;
    logic       lrclk;
    logic       sclk_rise;
    logic       sclk_fall;
    logic [4:0] count;
    logic       count_valid;
    logic       count_lrclk;
    logic       finish;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i2s_timing #(
        .DATA_BIT(24),
        .SLOT_BIT(32),
        .SCLK_DIV(4)
    ) dut (
        .i_clk_12_288 (clk),
        .i_reset      (rst),
        .i_enable     (en),
        .o_sclk       (sclk),
        .o_lrclk      (lrclk),
        .o_sclk_rise  (sclk_rise),
        .o_sclk_fall  (sclk_fall),
        .o_count      (count),
        .o_count_valid(count_valid),
        .o_count_lrclk(count_lrclk),
        .o_finish     (finish)
    );

    function automatic logic [11:0] outs();
        return {sclk, lrclk, sclk_rise, sclk_fall, count, count_valid, count_lrclk, finish};
    endfunction

    // Expected output vector in cycle n of a frame sequence started at cycle 0.
    function automatic logic [11:0] model(input int n);
        int d, b, p;
        logic s, lr, r, f, v, fin;
        logic [4:0] c;
        d   = n % 4;
        b   = (n / 4) % 64;
        p   = b % 32;
        s   = (d >= 2);
        r   = (d == 2);
        f   = (d == 0) && (n != 0);
        lr  = (b >= 32);
        v   = (p >= 1) && (p <= 24);
        c   = v ? 5'(24 - p) : 5'd0;
        fin = (b == 57) && (d == 0);
        return {s, lr, r, f, c, v, lr, fin};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (outs() !== 12'd0) begin
                errors++;
                $display("FAIL reset cycle %0d: got %h expected 000", i, outs());
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (outs() !== 12'd0) begin
                errors++;
                $display("FAIL idle cycle %0d: got %h expected 000", i, outs());
            end
        end
    endtask

    task automatic test_clock_gen();
        int rises = 0;
        int data_periods = 0;
        int fins[$];
        int exp_fins[4] = '{228, 484, 740, 996};
        en = 1'b1;
        for (int n = 0; n < 1024; n++) begin
            step();
            checks++;
            if (outs() !== model(n)) begin
                errors++;
                $display("FAIL clkgen cycle %0d: got %h expected %h", n, outs(), model(n));
            end
            if (sclk_rise) rises++;
            if (sclk_rise && count_valid) data_periods++;
            if (finish) fins.push_back(n);
            if (n == 6 || n == 98 || n == 134 || n == 226) begin
                checks++;
                if ({sclk_rise, count_valid, count_lrclk, count} !==
                    {1'b1, 1'b1, (n > 128), (n == 6 || n == 134) ? 5'd23 : 5'd0}) begin
                    errors++;
                    $display("FAIL msb_lsb cycle %0d: got rise=%b valid=%b ch=%b count=%0d",
                             n, sclk_rise, count_valid, count_lrclk, count);
                end
            end
        end
        en = 1'b0;
        checks++;
        if (rises !== 256) begin
            errors++;
            $display("FAIL rise_count: got %0d expected 256", rises);
        end
        checks++;
        if (data_periods !== 192) begin
            errors++;
            $display("FAIL data_periods: got %0d expected 192", data_periods);
        end
        checks++;
        if (fins.size() !== 4) begin
            errors++;
            $display("FAIL finish_count: got %0d expected 4", fins.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (fins[k] !== exp_fins[k]) begin
                    errors++;
                    $display("FAIL finish_cycle %0d: got %0d expected %0d", k, fins[k], exp_fins[k]);
                end
            end
        end
        step();
        step();
    endtask

    task automatic test_loopback();
        logic [23:0] word_l = 24'hA5C3F1;
        logic [23:0] word_r = 24'h123456;
        logic [23:0] sh_l = 24'd0;
        logic [23:0] sh_r = 24'd0;
        logic        sd = 1'b0;
        en = 1'b1;
        for (int n = 0; n < 230; n++) begin
            step();
            // Codec changes data on SCLK falling edge; receiver shifts on rising edge.
            if (sclk_fall) sd = count_valid ? (lrclk ? word_r[count] : word_l[count]) : 1'b0;
            if (sclk_rise && count_valid) begin
                if (count_lrclk) sh_r = {sh_r[22:0], sd};
                else             sh_l = {sh_l[22:0], sd};
            end
            if (n == 228) begin
                checks++;
                if (finish !== 1'b1) begin
                    errors++;
                    $display("FAIL loop_finish: got %b expected 1", finish);
                end
            end
            if (n == 229) begin
                checks++;
                if (sh_l !== 24'hA5C3F1) begin
                    errors++;
                    $display("FAIL loop_left: got %h expected a5c3f1", sh_l);
                end
                checks++;
                if (sh_r !== 24'h123456) begin
                    errors++;
                    $display("FAIL loop_right: got %h expected 123456", sh_r);
                end
            end
        end
        en = 1'b0;
        step();
        step();
    endtask

    task automatic test_abort();
        int fins = 0;
        logic [11:0] exp;
        en = 1'b1;
        for (int n = 0; n <= 431; n++) begin
            step();
            if (n <= 150)      exp = model(n);
            else if (n <= 200) exp = 12'd0;
            else               exp = model(n - 201);
            checks++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL abort cycle %0d: got %h expected %h", n, outs(), exp);
            end
            if (finish) begin
                fins++;
                checks++;
                if (n !== 429) begin
                    errors++;
                    $display("FAIL abort_finish_at: got cycle %0d expected 429", n);
                end
            end
            if (n == 150) en = 1'b0;
            if (n == 200) en = 1'b1;
        end
        checks++;
        if (fins !== 1) begin
            errors++;
            $display("FAIL abort_finish_count: got %0d expected 1", fins);
        end
        en = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset_priority();
        int fins = 0;
        logic [11:0] exp;
        en = 1'b1;
        for (int n = 0; n <= 331; n++) begin
            step();
            if (n <= 100)      exp = model(n);
            else if (n == 101) exp = 12'd0;
            else               exp = model(n - 102);
            checks++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL rstprio cycle %0d: got %h expected %h", n, outs(), exp);
            end
            if (finish) begin
                fins++;
                checks++;
                if (n !== 330) begin
                    errors++;
                    $display("FAIL rstprio_finish_at: got cycle %0d expected 330", n);
                end
            end
            if (n == 100) rst = 1'b1;
            if (n == 101) rst = 1'b0;
        end
        checks++;
        if (fins !== 1) begin
            errors++;
            $display("FAIL rstprio_finish_count: got %0d expected 1", fins);
        end
        en = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        test_reset();
        test_clock_gen();
        test_loopback();
        test_abort();
        test_reset_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
